// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit CPU: step counter, run/halt state, and the
// combinational decode of (step, opcode, flags, state) into the 16-bit control word.
module microcode_sequencer #(
  parameter int STEP_WIDTH = 3,
  parameter int EARLY_END  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_en,
  input  logic [3:0]            ir_opcode,
  input  logic                  flag_c,
  input  logic                  flag_z,
  output logic [15:0]           ctrl_word,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  halted,
  output logic                  fetch
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [15:0] C_HLT = 16'h0001;
  localparam logic [15:0] C_MI  = 16'h0002;
  localparam logic [15:0] C_RI  = 16'h0004;
  localparam logic [15:0] C_RO  = 16'h0008;
  localparam logic [15:0] C_IO  = 16'h0010;
  localparam logic [15:0] C_II  = 16'h0020;
  localparam logic [15:0] C_AI  = 16'h0040;
  localparam logic [15:0] C_AO  = 16'h0080;
  localparam logic [15:0] C_EO  = 16'h0100;
  localparam logic [15:0] C_SU  = 16'h0200;
  localparam logic [15:0] C_BI  = 16'h0400;
  localparam logic [15:0] C_OI  = 16'h0800;
  localparam logic [15:0] C_CE  = 16'h1000;
  localparam logic [15:0] C_CO  = 16'h2000;
  localparam logic [15:0] C_J   = 16'h4000;
  localparam logic [15:0] C_FI  = 16'h8000;

  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [STEP_WIDTH-1:0] T0  = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] T1  = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] T2  = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] T3  = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] T4  = STEP_WIDTH'(4);
  localparam logic [STEP_WIDTH-1:0] ONE = STEP_WIDTH'(1);

  logic [0:0]            state;
  logic [15:0]           exec_word;
  logic [15:0]           decode_word;
  logic [STEP_WIDTH-1:0] last_step;
  logic [STEP_WIDTH-1:0] end_step;
  logic [STEP_WIDTH-1:0] next_step;
  logic                  halt_entry;

  // Execute-phase words; steps outside an opcode's range (incl. 5..7) stay zero.
  always_comb begin
    exec_word = 16'h0000;
    last_step = T2;
    case (ir_opcode)
      OP_LDA: begin
        last_step = T3;
        if (step == T2) exec_word = C_IO | C_MI;
        else if (step == T3) exec_word = C_RO | C_AI;
      end
      OP_ADD, OP_SUB: begin
        last_step = T4;
        if (step == T2) exec_word = C_IO | C_MI;
        else if (step == T3) exec_word = C_RO | C_BI;
        else if (step == T4)
          exec_word = C_EO | C_AI | C_FI | ((ir_opcode == OP_SUB) ? C_SU : 16'h0000);
      end
      OP_STA: begin
        last_step = T3;
        if (step == T2) exec_word = C_IO | C_MI;
        else if (step == T3) exec_word = C_AO | C_RI;
      end
      OP_LDI: if (step == T2) exec_word = C_IO | C_AI;
      OP_JMP: if (step == T2) exec_word = C_IO | C_J;
      OP_JC:  if (step == T2 && flag_c) exec_word = C_IO | C_J;
      OP_JZ:  if (step == T2 && flag_z) exec_word = C_IO | C_J;
      OP_OUT: if (step == T2) exec_word = C_AO | C_OI;
      OP_HLT: if (step == T2) exec_word = C_HLT;
      default: ;
    endcase
  end

  always_comb begin
    decode_word = exec_word;
    if (step == T0) decode_word = C_CO | C_MI;
    else if (step == T1) decode_word = C_RO | C_II | C_CE;
  end

  // Fixed-length mode always runs to T4; out-of-range counters fall back to 0.
  assign end_step   = (EARLY_END != 0) ? last_step : T4;
  assign next_step  = (step >= end_step) ? T0 : step + ONE;
  assign halt_entry = (state == ST_RUN) && (step == T2) && (ir_opcode == OP_HLT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step  <= T0;
      state <= ST_RUN;
    end else if (step_en && state == ST_RUN) begin
      if (halt_entry) state <= ST_HALTED;
      else step <= next_step;
    end
  end

  always_comb begin
    ctrl_word = decode_word;
    if (!rst_n) ctrl_word = 16'h0000;
    else if (state == ST_HALTED) ctrl_word = C_HLT;
  end

  assign halted = rst_n && (state == ST_HALTED);
  assign fetch  = !halted && (step <= T1);

endmodule
